// File: rtl/victim_select.sv
// victim_select: three-stage pipelined 64-way priority reduction.
// It finds the square with the highest prio. On a tie the lowest index wins.
// It returns that square's index, its prio and a one-hot select vector.
// It also reports whether any square flagged an attacked enemy king.
module victim_select #(
    parameter int SQUARES = 64,
    parameter int PRIO_W  = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      sample,
    input  logic                      flush,
    input  logic [SQUARES*PRIO_W-1:0] prio_bus,
    input  logic [SQUARES-1:0]        king_bus,
    output logic                      out_valid,
    output logic [5:0]                best_sq,
    output logic [PRIO_W-1:0]         best_prio,
    output logic                      found,
    output logic [SQUARES-1:0]        select,
    output logic                      king_hit,
    output logic                      busy
);

    localparam int IDX_W = 6;
    localparam int N1    = SQUARES / 4;   // stage-1 group winners
    localparam int N2    = N1 / 4;        // stage-2 group winners

    // ------------------------------------------------------------------
    // Stage 1: 16 groups of 4 squares each
    // ------------------------------------------------------------------
    logic [N1*PRIO_W-1:0] s1_prio_next;
    logic [N1*PRIO_W-1:0] s1_prio_reg;
    logic [N1*IDX_W-1:0]  s1_idx_next;
    logic [N1*IDX_W-1:0]  s1_idx_reg;
    logic [N1-1:0]        s1_king_next;
    logic [N1-1:0]        s1_king_reg;
    logic                 v1_reg;

    genvar gi;
    generate
        for (gi = 0; gi < N1; gi++) begin : g_s1
            logic [PRIO_W-1:0] win_prio;
            logic [IDX_W-1:0]  win_idx;

            // Scan the group in ascending index order.
            // Only a strictly greater prio displaces the incumbent.
            always_comb begin
                win_prio = prio_bus[(4*gi)*PRIO_W +: PRIO_W];
                win_idx  = IDX_W'(4*gi);
                for (int k = 1; k < 4; k++) begin
                    if (prio_bus[(4*gi+k)*PRIO_W +: PRIO_W] > win_prio) begin
                        win_prio = prio_bus[(4*gi+k)*PRIO_W +: PRIO_W];
                        win_idx  = IDX_W'(4*gi+k);
                    end
                end
            end

            assign s1_prio_next[gi*PRIO_W +: PRIO_W] = win_prio;
            assign s1_idx_next[gi*IDX_W +: IDX_W]    = win_idx;
            assign s1_king_next[gi]                  = |king_bus[4*gi +: 4];
        end
    endgenerate

    // Stage-1 data registers.
    // They load every cycle; v1_reg says whether the contents mean anything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_prio_reg <= '0;
            s1_idx_reg  <= '0;
            s1_king_reg <= '0;
        end else begin
            s1_prio_reg <= s1_prio_next;
            s1_idx_reg  <= s1_idx_next;
            s1_king_reg <= s1_king_next;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: 4 groups of 4 stage-1 winners
    // ------------------------------------------------------------------
    logic [N2*PRIO_W-1:0] s2_prio_next;
    logic [N2*PRIO_W-1:0] s2_prio_reg;
    logic [N2*IDX_W-1:0]  s2_idx_next;
    logic [N2*IDX_W-1:0]  s2_idx_reg;
    logic [N2-1:0]        s2_king_next;
    logic [N2-1:0]        s2_king_reg;
    logic                 v2_reg;

    generate
        for (gi = 0; gi < N2; gi++) begin : g_s2
            logic [PRIO_W-1:0] win_prio;
            logic [IDX_W-1:0]  win_idx;

            // Stage-1 winners arrive in ascending square order.
            // A strict compare therefore keeps the lowest-index tie-break.
            always_comb begin
                win_prio = s1_prio_reg[(4*gi)*PRIO_W +: PRIO_W];
                win_idx  = s1_idx_reg[(4*gi)*IDX_W +: IDX_W];
                for (int k = 1; k < 4; k++) begin
                    if (s1_prio_reg[(4*gi+k)*PRIO_W +: PRIO_W] > win_prio) begin
                        win_prio = s1_prio_reg[(4*gi+k)*PRIO_W +: PRIO_W];
                        win_idx  = s1_idx_reg[(4*gi+k)*IDX_W +: IDX_W];
                    end
                end
            end

            assign s2_prio_next[gi*PRIO_W +: PRIO_W] = win_prio;
            assign s2_idx_next[gi*IDX_W +: IDX_W]    = win_idx;
            assign s2_king_next[gi]                  = |s1_king_reg[4*gi +: 4];
        end
    endgenerate

    // Stage-2 data registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_prio_reg <= '0;
            s2_idx_reg  <= '0;
            s2_king_reg <= '0;
        end else begin
            s2_prio_reg <= s2_prio_next;
            s2_idx_reg  <= s2_idx_next;
            s2_king_reg <= s2_king_next;
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: final 4-to-1 reduction and result decode
    // ------------------------------------------------------------------
    logic [PRIO_W-1:0]  fin_prio;
    logic [IDX_W-1:0]   fin_idx;
    logic               fin_found;
    logic [SQUARES-1:0] fin_select;
    logic               fin_king;

    // Pick the final winner and decode the one-hot select.
    // An empty board (no non-zero prio) reports square 0 with no select bit.
    always_comb begin
        fin_prio = s2_prio_reg[0 +: PRIO_W];
        fin_idx  = s2_idx_reg[0 +: IDX_W];
        for (int k = 1; k < N2; k++) begin
            if (s2_prio_reg[k*PRIO_W +: PRIO_W] > fin_prio) begin
                fin_prio = s2_prio_reg[k*PRIO_W +: PRIO_W];
                fin_idx  = s2_idx_reg[k*IDX_W +: IDX_W];
            end
        end
        fin_found  = (fin_prio != '0);
        fin_select = '0;
        if (fin_found) begin
            fin_select[fin_idx] = 1'b1;
        end
        fin_king = |s2_king_reg;
    end

    // Result registers.
    // They change only when a valid stage-2 sample completes and no flush
    // is pending; otherwise they hold the previous result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            best_sq   <= '0;
            best_prio <= '0;
            found     <= 1'b0;
            select    <= '0;
            king_hit  <= 1'b0;
        end else if (v2_reg && !flush) begin
            best_sq   <= fin_idx;
            best_prio <= fin_prio;
            found     <= fin_found;
            select    <= fin_select;
            king_hit  <= fin_king;
        end
    end

    // ------------------------------------------------------------------
    // Valid pipeline: flush squashes every stage, including a new sample
    // ------------------------------------------------------------------
    // Advance the valid bits one stage per clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_reg    <= 1'b0;
            v2_reg    <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            v1_reg    <= sample && !flush;
            v2_reg    <= v1_reg && !flush;
            out_valid <= v2_reg && !flush;
        end
    end

    assign busy = v1_reg | v2_reg | out_valid;

endmodule

// File: tb/tb_victim_select.sv
// tb_victim_select: scoreboard bench for victim_select.
// Each sample pushes its expected result and due cycle into a queue.
// Each out_valid pops the queue and compares against it.
module tb_victim_select;

    typedef struct packed {
        logic [5:0]  sq;
        logic [2:0]  p;
        logic        found;
        logic [63:0] sel;
        logic        king;
    } res_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         sample;
    logic         flush;
    logic [191:0] prio_bus;
    logic [63:0]  king_bus;
    logic         out_valid;
    logic [5:0]   best_sq;
    logic [2:0]   best_prio;
    logic         found;
    logic [63:0]  select;
    logic         king_hit;
    logic         busy;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   cycle_cnt = 0;
    res_t exp_q[$];
    int   due_q[$];
    res_t last_exp = '0;

    victim_select #(.SQUARES(64), .PRIO_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .sample    (sample),
        .flush     (flush),
        .prio_bus  (prio_bus),
        .king_bus  (king_bus),
        .out_valid (out_valid),
        .best_sq   (best_sq),
        .best_prio (best_prio),
        .found     (found),
        .select    (select),
        .king_hit  (king_hit),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    // Reference model: a linear scan over all 64 squares.
    // Only a strictly greater prio replaces the current best.
    function automatic res_t model(input logic [191:0] p, input logic [63:0] k);
        res_t       r;
        logic [2:0] bp;
        int         bi;
        bp = '0;
        bi = 0;
        for (int i = 0; i < 64; i++) begin
            if (p[3*i +: 3] > bp) begin
                bp = p[3*i +: 3];
                bi = i;
            end
        end
        r.sq    = 6'(bi);
        r.p     = bp;
        r.found = (bp != 3'd0);
        r.sel   = '0;
        if (r.found) r.sel[bi] = 1'b1;
        r.king  = |k;
        return r;
    endfunction

    function automatic res_t cur_out();
        res_t r;
        r.sq    = best_sq;
        r.p     = best_prio;
        r.found = found;
        r.sel   = select;
        r.king  = king_hit;
        return r;
    endfunction

    task automatic test_reset();
        rst = 1'b1; sample = 1'b0; flush = 1'b0; prio_bus = '0; king_bus = '0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({cur_out(), out_valid, busy} !== '0) begin
            $display("FAIL reset_state: got sq=%0d p=%0d f=%b sel=%h k=%b ov=%b busy=%b, want all 0",
                     best_sq, best_prio, found, select, king_hit, out_valid, busy);
        end else begin
            n_pass++;
            $display("[reset] outputs zero");
        end
        rst = 1'b0;
    endtask

    // Four isolated samples from the directed table, one every 5 cycles.
    task automatic test_patterns();
        logic [191:0] pt[4];
        logic [63:0]  kt[4];
        string        nm[4];
        res_t         e, a;
        int           d, j;
        for (int i = 0; i < 4; i++) begin pt[i] = '0; kt[i] = '0; end
        pt[0][3*12 +: 3] = 3'd7;                                nm[0] = "single_hit";
        pt[1][3*5 +: 3] = 3'd6; pt[1][3*40 +: 3] = 3'd6;
        pt[1][3*63 +: 3] = 3'd5;                                nm[1] = "tie_break";
                                                                nm[2] = "empty_board";
        pt[3][3*9 +: 3] = 3'd3; kt[3][60] = 1'b1;               nm[3] = "king_flag";
        j = 0;
        for (int c = 0; c < 26; c++) begin
            @(negedge clk);
            if (out_valid) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL spurious_out_valid: got out_valid=1 at cycle %0d, want no pulse", cycle_cnt);
                end else begin
                    e = exp_q.pop_front(); d = due_q.pop_front(); a = cur_out();
                    if (a !== e || cycle_cnt != d) begin
                        $display("FAIL %s: got sq=%0d p=%0d f=%b sel=%h k=%b cyc=%0d, want sq=%0d p=%0d f=%b sel=%h k=%b cyc=%0d",
                                 nm[j], a.sq, a.p, a.found, a.sel, a.king, cycle_cnt, e.sq, e.p, e.found, e.sel, e.king, d);
                    end else begin
                        n_pass++;
                        $display("[%s] sq=%0d p=%0d f=%b k=%b", nm[j], a.sq, a.p, a.found, a.king);
                    end
                    last_exp = e;
                    j++;
                end
            end
            if (c % 5 == 0 && c / 5 < 4) begin
                sample = 1'b1; prio_bus = pt[c/5]; king_bus = kt[c/5];
                exp_q.push_back(model(pt[c/5], kt[c/5]));
                due_q.push_back(cycle_cnt + 3);
            end else begin
                sample = 1'b0;
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            $display("FAIL patterns_drain: got %0d results outstanding, want 0", exp_q.size());
        end else n_pass++;
        exp_q.delete(); due_q.delete();
    endtask

    // Back-to-back random boards with frequent ties and empty boards.
    task automatic test_random();
        logic [191:0] p;
        logic [63:0]  k;
        res_t         e, a;
        int           d;
        for (int c = 0; c < 36; c++) begin
            @(negedge clk);
            if (out_valid) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL spurious_out_valid: got out_valid=1 at cycle %0d, want no pulse", cycle_cnt);
                end else begin
                    e = exp_q.pop_front(); d = due_q.pop_front(); a = cur_out();
                    if (a !== e || cycle_cnt != d) begin
                        $display("FAIL random: got sq=%0d p=%0d f=%b sel=%h k=%b cyc=%0d, want sq=%0d p=%0d f=%b sel=%h k=%b cyc=%0d",
                                 a.sq, a.p, a.found, a.sel, a.king, cycle_cnt, e.sq, e.p, e.found, e.sel, e.king, d);
                    end else begin
                        n_pass++;
                        $display("[random] sq=%0d p=%0d f=%b k=%b", a.sq, a.p, a.found, a.king);
                    end
                    last_exp = e;
                end
            end
            if (c < 30) begin
                p = '0;
                if (c % 7 != 3) begin
                    for (int i = 0; i < 64; i++)
                        if ($urandom_range(0, 4) == 0) p[3*i +: 3] = 3'($urandom_range(0, 7));
                end
                k = '0;
                if ($urandom_range(0, 2) == 0) k[$urandom_range(0, 63)] = 1'b1;
                sample = 1'b1; prio_bus = p; king_bus = k;
                exp_q.push_back(model(p, k));
                due_q.push_back(cycle_cnt + 3);
            end else begin
                sample = 1'b0;
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            $display("FAIL random_drain: got %0d results outstanding, want 0", exp_q.size());
        end else n_pass++;
        exp_q.delete(); due_q.delete();
    endtask

    // Three consecutive samples, then confirm the last result holds.
    task automatic test_back_to_back();
        logic [191:0] pt[3];
        res_t         e, a;
        int           d;
        for (int i = 0; i < 3; i++) pt[i] = '0;
        pt[0][3*1 +: 3]  = 3'd2;
        pt[1][3*63 +: 3] = 3'd7;
        pt[2][3*30 +: 3] = 3'd4;
        king_bus = '0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (out_valid) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL spurious_out_valid: got out_valid=1 at cycle %0d, want no pulse", cycle_cnt);
                end else begin
                    e = exp_q.pop_front(); d = due_q.pop_front(); a = cur_out();
                    if (a !== e || cycle_cnt != d) begin
                        $display("FAIL back_to_back: got sq=%0d p=%0d sel=%h cyc=%0d, want sq=%0d p=%0d sel=%h cyc=%0d",
                                 a.sq, a.p, a.sel, cycle_cnt, e.sq, e.p, e.sel, d);
                    end else begin
                        n_pass++;
                        $display("[back_to_back] sq=%0d p=%0d", a.sq, a.p);
                    end
                    last_exp = e;
                end
            end
            if (c < 3) begin
                sample = 1'b1; prio_bus = pt[c];
                exp_q.push_back(model(pt[c], '0));
                due_q.push_back(cycle_cnt + 3);
            end else begin
                sample = 1'b0;
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            $display("FAIL b2b_drain: got %0d results outstanding, want 0", exp_q.size());
        end else n_pass++;
        exp_q.delete(); due_q.delete();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b0 || cur_out() !== last_exp || best_sq !== 6'd30 || best_prio !== 3'd4) begin
                $display("FAIL b2b_hold: got ov=%b sq=%0d p=%0d, want ov=0 sq=30 p=4", out_valid, best_sq, best_prio);
            end else begin
                n_pass++;
                $display("[b2b_hold] sq=%0d p=%0d held", best_sq, best_prio);
            end
        end
    endtask

    // Flush drops in-flight work.
    // Reset clears everything at once and leaves nothing pending.
    task automatic test_flush_reset();
        logic [191:0] p;
        p = '0; p[3*20 +: 3] = 3'd5;
        @(negedge clk);
        sample = 1'b1; flush = 1'b0; prio_bus = p; king_bus = 64'h1;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) $display("FAIL busy_after_sample: got %b, want 1", busy);
        else n_pass++;
        sample = 1'b0; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL busy_after_flush: got %b, want 0", busy);
        else n_pass++;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b0 || cur_out() !== last_exp) begin
                $display("FAIL flush_hold: got ov=%b sq=%0d p=%0d k=%b, want ov=0 sq=%0d p=%0d k=%b",
                         out_valid, best_sq, best_prio, king_hit, last_exp.sq, last_exp.p, last_exp.king);
            end else begin
                n_pass++;
                $display("[flush] no out_valid, sq=%0d p=%0d held", best_sq, best_prio);
            end
        end
        // A sample that coincides with flush is dropped.
        sample = 1'b1; flush = 1'b1;
        @(negedge clk);
        sample = 1'b0; flush = 1'b0;
        for (int c = 0; c < 4; c++) begin
            n_checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                $display("FAIL flush_with_sample: got ov=%b busy=%b, want 0 0", out_valid, busy);
            end else n_pass++;
            @(negedge clk);
        end
        $display("[flush_with_sample] sample dropped");
        // Reset in flight: outputs must clear asynchronously.
        sample = 1'b1;
        @(negedge clk);
        sample = 1'b0; rst = 1'b1;
        #1;
        n_checks++;
        if ({cur_out(), out_valid, busy} !== '0) begin
            $display("FAIL async_reset: got sq=%0d p=%0d f=%b sel=%h k=%b ov=%b busy=%b, want all 0",
                     best_sq, best_prio, found, select, king_hit, out_valid, busy);
        end else begin
            n_pass++;
            $display("[async_reset] outputs zero");
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0 || best_sq !== 6'd0) begin
                $display("FAIL post_reset: got ov=%b busy=%b sq=%0d, want 0 0 0", out_valid, busy, best_sq);
            end else n_pass++;
        end
        $display("[post_reset] no out_valid after release");
    endtask

    initial begin
        test_reset();
        test_patterns();
        test_random();
        test_back_to_back();
        test_flush_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/victim_select.md
# victim_select

Pipelined 64-way priority reduction that consumes the per-square `prio` and `king` outputs of the 8×8 `square` array. After each find phase (victim, aggressor or pivot) the controller samples the array once. This block returns the winning square index, its priority and a one-hot select vector, which the controller drives back onto the squares' `ss1` lines for the next phase. It also flags whether any square reported an attacked enemy king, i.e. the previous move was illegal.

## Interface

Parameters:
- `SQUARES`, default 64: number of squares. Only 64 is supported.
- `PRIO_W`, default 3: width of each square's priority field.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `sample` in 1: capture `prio_bus`/`king_bus` this cycle.
- `flush` in 1: discard all in-flight samples (synchronous).
- `prio_bus` in 192: square i priority at bits [3i+2:3i]; square 0 = a1, square 63 = h8.
- `king_bus` in 64: square i `king` flag at bit i.
- `out_valid` out 1: one-cycle pulse when a result is presented.
- `best_sq` out 6: index of the winning square.
- `best_prio` out 3: priority of the winning square.
- `found` out 1: `best_prio` != 0.
- `select` out 64: one-hot of `best_sq` when `found`, else all zero.
- `king_hit` out 1: OR of the sampled `king_bus`.
- `busy` out 1: any pipeline stage holds a valid sample.

## Operation

Selection rule:
- The winner is the maximum `prio`.
- Ties go to the lowest square index.
- If all priorities are 0: `best_sq`=0, `best_prio`=0, `found`=0, `select`=0.

Pipeline: three registered stages, each with its own valid bit.
- S1: 16 groups of 4 squares. Registers {prio, idx[5:0]} of each group winner, the OR of each group's king bits, and `v1` = `sample`.
- S2: 4 groups of 4 S1 winners. Registers {prio, idx}, the king ORs, and `v2` = `v1`.
- S3 (output): final 4→1 reduction. Registers `best_prio`, `best_sq`, `found`, `select` (decoded from the final winner), `king_hit`, and `out_valid` = `v2`.

Comparisons:
- Unsigned 3-bit.
- At every stage a candidate replaces the incumbent only on strictly greater priority. Candidates are scanned in ascending index order, so lowest-index tie-breaking holds globally.

Result hold:
- `best_sq`, `best_prio`, `found`, `select` and `king_hit` load only when `v2`=1.
- They hold their value until the next result.
- `out_valid` is high only in the cycle the result loads.

Handshake:
- No backpressure. `sample` may be asserted every cycle, and each assertion yields exactly one `out_valid` pulse, in order.
- When `sample`=0 the stage data registers may load don't-care values, but their valid bits are 0 and the result registers do not update.

`busy` = `v1` | `v2` | `out_valid`.

Flush:
- `flush`=1 clears `v1`, `v2` and `out_valid` at the next edge.
- It takes priority over a simultaneous `sample`; that sample is dropped.
- Held result registers keep their last values.

## Timing

- Latency 3: `sample` high before edge N leads to `out_valid`=1 and new outputs during the cycle after edge N+2.
- Throughput: one sample per cycle.
- Reset: asynchronous assertion immediately clears all valid bits, `out_valid`, `busy`, `best_sq`, `best_prio`, `found`, `select` and `king_hit` to 0. Stage data registers also clear to 0.
- Reset mid-operation: in-flight samples are lost, and no `out_valid` follows reset release unless `sample` is reasserted.
- Deassertion of `rst` is synchronised externally. The first edge after release may accept `sample`.
- Sampling window: `prio_bus` and `king_bus` are combinational outputs of the square array. The controller asserts `sample` only in a cycle where `state_mode`/`mask_mode` have been stable for at least one cycle. This block does not check that.

## Test plan

- Single hit: square 12 prio=7, all others 0, `sample` 1 cycle → exactly 3 edges later `out_valid`=1, `best_sq`=12, `best_prio`=7, `found`=1, `select`=1<<12, `king_hit`=0.
- Tie-break across groups: squares 5 and 40 prio=6, square 63 prio=5 → `best_sq`=5, `best_prio`=6, `select`=1<<5.
- Empty board result: all prio 0, `king_bus`=0 → `found`=0, `best_sq`=0, `select`=0, `out_valid` still pulses once.
- King flag: `king_bus` bit 60 set, square 9 prio=3 → `king_hit`=1, `best_sq`=9, `best_prio`=3.
- Back-to-back: three consecutive samples {sq 1 p2}, {sq 63 p7}, {sq 30 p4} → three consecutive `out_valid` cycles returning 1/2, 63/7, 30/4 in order. Outputs hold 30/4 afterward while `out_valid`=0.
- Flush and reset: sample, then `flush` on the next cycle → no `out_valid`, previous result held. Then sample and assert `rst` one cycle later → all outputs 0 immediately, no `out_valid` after release.
